cla_add8_scheduler: RTL and testbench

//   Shares one 4-bit cla_adder between two requesters, each asking for an 8-bit add.

---
 rtl/cla_add8_scheduler_if.sv | 33 +++
 rtl/cla_add8_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_cla_add8_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_add8_scheduler_if.sv
// -----------------------------------------------------------------------------
// cla_add8_scheduler_if
//   Bus between the 8-bit add scheduler and the shared 4-bit cla_adder.
//   master: the scheduler (issues nibble operands, consumes the adder result)
//   slave : the cla_adder  (consumes operands, returns sum/carry with ready)
// Signals
//   add_en    1  one-cycle enable that starts a nibble add
//   add_a     4  nibble operand A
//   add_b     4  nibble operand B (already inverted when subtracting)
//   add_cin   1  nibble carry-in
//   add_ready 1  adder result valid
//   add_sum   4  adder nibble sum
//   add_cout  1  adder carry out of bit 3
// -----------------------------------------------------------------------------
interface cla_add8_scheduler_if;
   logic       add_en;
   logic [3:0] add_a;
   logic [3:0] add_b;
   logic       add_cin;
   logic       add_ready;
   logic [3:0] add_sum;
   logic       add_cout;

   modport master (
      output add_en, add_a, add_b, add_cin,
      input  add_ready, add_sum, add_cout
   );

   modport slave (
      input  add_en, add_a, add_b, add_cin,
      output add_ready, add_sum, add_cout
   );
endinterface

// File: rtl/cla_add8_scheduler.sv
// -----------------------------------------------------------------------------
// cla_add8_scheduler
//   Shares one 4-bit cla_adder between two requesters that each need an 8-bit
//   add. Requester 0 is the ALU, requester 1 the PC incrementer. Every add is
//   two adder passes: the low nibble first, then the high nibble with the low
//   pass carry chained in. A round-robin pointer picks who is served when both
//   ask in the same IDLE cycle.
//
// Optional feature
//   CLA_SCHED_SUB_EN  when defined, sub0/sub1 select subtraction: B is applied
//                     inverted and the low-pass carry-in is forced to 1
//                     (c_out=1 then means "no borrow"). When undefined, the
//                     sub inputs are ignored and every operation is an add.
//
// Parameters
//   TIMEOUT  cycles to wait for add_ready in each pass before aborting (1..255)
//   RR_INIT  requester that holds priority after reset (0 or 1)
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req0/req1       request, held with stable operands until its ack
//   a0/a1, b0/b1    8-bit operands per requester
//   cin0/cin1       carry-in per requester
//   sub0/sub1       subtract select per requester (CLA_SCHED_SUB_EN only)
//   ack0/ack1       one-cycle pulse: result/c_out/ovf/err valid for requester
//   result          8-bit sum, held until the next ack
//   c_out           carry out of bit 7
//   ovf             signed overflow
//   err             operation aborted on timeout (result/c_out/ovf forced 0)
//   busy            high whenever the FSM is not idle
//   add             master side of the cla_adder bus
// -----------------------------------------------------------------------------
module cla_add8_scheduler #(
   parameter int TIMEOUT = 15,
   parameter bit RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [7:0]  a0,
   input  logic [7:0]  a1,
   input  logic [7:0]  b0,
   input  logic [7:0]  b1,
   input  logic        cin0,
   input  logic        cin1,
   input  logic        sub0,
   input  logic        sub1,
   output logic        ack0,
   output logic        ack1,
   output logic [7:0]  result,
   output logic        c_out,
   output logic        ovf,
   output logic        err,
   output logic        busy,
   cla_add8_scheduler_if.master add
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LO_ISSUE = 3'd1;
   localparam logic [2:0] S_LO_WAIT  = 3'd2;
   localparam logic [2:0] S_HI_ISSUE = 3'd3;
   localparam logic [2:0] S_HI_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   // Last counter value before a wait is abandoned: the counter starts at 0 on
   // entry, so a wait gives up after TIMEOUT cycles without add_ready.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [2:0] state;
   logic       ptr;        // requester holding priority on a tie
   logic       grant;      // requester currently being served
   logic       other_req;  // the non-granted requester was also asking at grant
   logic [7:0] op_a;
   logic [7:0] op_b;       // B exactly as applied to the adder
   logic       op_cin;     // low-pass carry-in exactly as applied
   logic       carry;      // carry out of the low pass
   logic [3:0] res_lo;
   logic [7:0] cnt;

   // Arbitration and operand selection for the IDLE cycle.
   logic       grant_next;
   logic [7:0] sel_a;
   logic [7:0] sel_b;
   logic       sel_cin;

   assign grant_next = (req0 && req1) ? ptr : req1;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_a   = grant_next ? a1   : a0;
      sel_b   = grant_next ? b1   : b0;
      sel_cin = grant_next ? cin1 : cin0;
`ifdef CLA_SCHED_SUB_EN
      // Two's-complement subtract: a + ~b + 1.
      if (grant_next ? sub1 : sub0) begin
         sel_b   = ~sel_b;
         sel_cin = 1'b1;
      end
`endif
   end

`ifndef CLA_SCHED_SUB_EN
   // Subtract selects have no function in an add-only build.
   logic unused_sub;
   assign unused_sub = sub0 ^ sub1;
`endif

   assign busy = (state != S_IDLE);

   // Adder bus: operands stay stable through the matching WAIT state.
   always_comb begin
      add.add_en  = 1'b0;
      add.add_a   = 4'h0;
      add.add_b   = 4'h0;
      add.add_cin = 1'b0;
      case (state)
         S_LO_ISSUE, S_LO_WAIT: begin
            add.add_en  = (state == S_LO_ISSUE);
            add.add_a   = op_a[3:0];
            add.add_b   = op_b[3:0];
            add.add_cin = op_cin;
         end
         S_HI_ISSUE, S_HI_WAIT: begin
            add.add_en  = (state == S_HI_ISSUE);
            add.add_a   = op_a[7:4];
            add.add_b   = op_b[7:4];
            add.add_cin = carry;
         end
         default: ;
      endcase
   end

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   // NOTE: the latched operands are reset as well; reset must force every
   // output to 0 and the adder bus is driven from these registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= RR_INIT;
         grant     <= 1'b0;
         other_req <= 1'b0;
         op_a      <= 8'h00;
         op_b      <= 8'h00;
         op_cin    <= 1'b0;
         carry     <= 1'b0;
         res_lo    <= 4'h0;
         cnt       <= 8'h00;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         result    <= 8'h00;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  grant     <= grant_next;
                  other_req <= req0 && req1;
                  op_a      <= sel_a;
                  op_b      <= sel_b;
                  op_cin    <= sel_cin;
                  state     <= S_LO_ISSUE;
               end
            end

            S_LO_ISSUE: begin
               cnt   <= 8'h00;
               state <= S_LO_WAIT;
            end

            S_HI_ISSUE: begin
               cnt   <= 8'h00;
               state <= S_HI_WAIT;
            end

            S_LO_WAIT, S_HI_WAIT: begin
               // add_ready takes precedence over an expiring counter.
               if (add.add_ready) begin
                  if (state == S_LO_WAIT) begin
                     res_lo <= add.add_sum;
                     carry  <= add.add_cout;
                     state  <= S_HI_ISSUE;
                  end else begin
                     result <= {add.add_sum, res_lo};
                     c_out  <= add.add_cout;
                     // Operands of equal sign giving a result of the other sign.
                     ovf    <= (op_a[7] ~^ op_b[7]) & (add.add_sum[3] ^ op_a[7]);
                     err    <= 1'b0;
                     ack0   <= ~grant;
                     ack1   <= grant;
                     state  <= S_DONE;
                  end
               end else if (cnt == TIMEOUT_LAST) begin
                  result <= 8'h00;
                  c_out  <= 1'b0;
                  ovf    <= 1'b0;
                  err    <= 1'b1;
                  ack0   <= ~grant;
                  ack1   <= grant;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            S_DONE: begin
               // Priority passes on only if the other side was actually waiting.
               if (other_req) begin
                  ptr <= ~grant;
               end
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_add8_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cla_add8_scheduler
//   Self-checking bench for cla_add8_scheduler. A behavioural cla_adder drives
//   the adder bus with selectable ready behaviour; stimulus pushes expected
//   responses into a scoreboard queue and an independent monitor compares them
//   against each ack. The reference model uses plain 8-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_cla_add8_scheduler;

   localparam int TIMEOUT = 15;
`ifdef CLA_SCHED_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] a0 = 8'h00, a1 = 8'h00, b0 = 8'h00, b1 = 8'h00;
   logic       cin0 = 1'b0, cin1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
   logic       ack0, ack1;
   logic [7:0] result;
   logic       c_out, ovf, err, busy;

   always #5 clk = ~clk;

   cla_add8_scheduler_if bus();

   // Behavioural 4-bit adder; ready pattern chosen by ready_mode:
   // 0 always ready, 1 random stalls of at most 3 cycles, 2 never ready.
   int   ready_mode = 0;
   int   low_run = 0;
   logic ready_q = 1'b1;
   assign bus.add_ready = ready_q;
   assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

   initial begin
      forever begin
         @(negedge clk);
         case (ready_mode)
            0: ready_q = 1'b1;
            1: begin
               if (low_run >= 3 || $urandom_range(0, 3) != 0) begin
                  ready_q = 1'b1;
                  low_run = 0;
               end else begin
                  ready_q = 1'b0;
                  low_run++;
               end
            end
            default: ready_q = 1'b0;
         endcase
      end
   end

   cla_add8_scheduler #(.TIMEOUT(TIMEOUT), .RR_INIT(1'b0)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0),
      .req1   (req1),
      .a0     (a0),
      .a1     (a1),
      .b0     (b0),
      .b1     (b1),
      .cin0   (cin0),
      .cin1   (cin1),
      .sub0   (sub0),
      .sub1   (sub1),
      .ack0   (ack0),
      .ack1   (ack1),
      .result (result),
      .c_out  (c_out),
      .ovf    (ovf),
      .err    (err),
      .busy   (busy),
      .add    (bus)
   );

   typedef struct {
      bit         id;
      logic [7:0] res;
      logic       co;
      logic       ov;
      logic       er;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   ptr = 1'b0;   // model of who wins a tie

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // Reference: 8-bit modulo add of A, effective B and effective carry-in.
   function automatic exp_t model(input bit id, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub);
      exp_t       e;
      logic [7:0] bb;
      logic       c;
      int         s;
      bb = b;
      c  = cin;
      if (sub && SUB_EN) begin
         bb = ~b;
         c  = 1'b1;
      end
      s    = int'(a) + int'(bb) + int'(c);
      e.id = id;
      e.res = s[7:0];
      e.co  = s[8];
      e.ov  = (a[7] == bb[7]) && (s[7] != a[7]);
      e.er  = 1'b0;
      return e;
   endfunction

   // Monitor: compares every ack with the scoreboard head and checks that the
   // result holds between acks.
   initial begin
      exp_t       e;
      logic [7:0] last_res;
      last_res = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            last_res = 8'h00;
         end else if (ack0 || ack1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: ack0=%0b ack1=%0b, expected no ack", ack0, ack1);
            end else begin
               e = q.pop_front();
               check("ack_one_hot", !(ack0 && ack1),
                     $sformatf("ack0=%0b ack1=%0b, expected one", ack0, ack1));
               check("ack_id", ack1 == e.id, $sformatf("got ack1=%0b, expected id %0d", ack1, e.id));
               check("result", result == e.res, $sformatf("got %02h, expected %02h", result, e.res));
               check("c_out", c_out == e.co, $sformatf("got %0b, expected %0b", c_out, e.co));
               check("ovf", ovf == e.ov, $sformatf("got %0b, expected %0b", ovf, e.ov));
               check("err", err == e.er, $sformatf("got %0b, expected %0b", err, e.er));
            end
            last_res = result;
         end else begin
            check("result_hold", result == last_res,
                  $sformatf("got %02h, expected held %02h", result, last_res));
         end
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      ptr   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issue one request pattern and wait until every raised request is acked.
   task automatic do_round(input bit r0, input bit r1,
                           input logic [7:0] xa0, input logic [7:0] xb0, input logic xc0, input logic xs0,
                           input logic [7:0] xa1, input logic [7:0] xb1, input logic xc1, input logic xs1);
      exp_t e0, e1;
      int   n;
      @(negedge clk);
      a0 = xa0; b0 = xb0; cin0 = xc0; sub0 = xs0;
      a1 = xa1; b1 = xb1; cin1 = xc1; sub1 = xs1;
      e0 = model(1'b0, xa0, xb0, xc0, xs0);
      e1 = model(1'b1, xa1, xb1, xc1, xs1);
      if (r0 && r1) begin
         // Tie: priority holder first; priority then passes to the other, which
         // is served alone afterwards and so keeps it.
         if (!ptr) begin q.push_back(e0); q.push_back(e1); end
         else      begin q.push_back(e1); q.push_back(e0); end
         ptr = ~ptr;
      end else if (r0) begin
         q.push_back(e0);
      end else if (r1) begin
         q.push_back(e1);
      end
      req0 = r0;
      req1 = r1;
      n = 0;
      while ((req0 || req1) && n < 200) begin
         @(negedge clk);
         n++;
         if (ack0) req0 = 1'b0;
         if (ack1) req1 = 1'b0;
      end
      check("round_complete", !(req0 || req1),
            $sformatf("req0=%0b req1=%0b still pending after %0d cycles, expected both acked", req0, req1, n));
      if (req0 || req1) begin
         q.delete();
         reset_dut();
      end
   endtask

   // Single request on port 0, counting rising edges from request to ack.
   task automatic timed_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc, output int lat);
      @(negedge clk);
      a0 = xa; b0 = xb; cin0 = xc; sub0 = 1'b0;
      req0 = 1'b1;
      lat = 0;
      while (!ack0 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("ack_seen", ack0 == 1'b1, $sformatf("ack0=%0b after %0d cycles, expected 1", ack0, lat));
      req0 = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   lat;
      exp_t e;
      logic [7:0] ra, rb, rc, rd;

      // Reset state.
      repeat (2) @(negedge clk);
      check("reset_outputs",
            {ack0, ack1, result, c_out, ovf, err, busy, bus.add_en, bus.add_a, bus.add_b, bus.add_cin} == '0,
            $sformatf("result=%02h busy=%0b add_en=%0b ack=%0b%0b, expected all 0",
                      result, busy, bus.add_en, ack0, ack1));
      rst_n = 1'b1;
      @(negedge clk);

      // 1) Simple add; ack in the 6th cycle counting the request cycle.
      q.push_back(model(1'b0, 8'h01, 8'h02, 1'b0, 1'b0));
      timed_op(8'h01, 8'h02, 1'b0, lat);
      check("latency", lat + 1 == 6, $sformatf("got %0d cycles, expected 6", lat + 1));

      // 2) Carry from low nibble into high nibble.
      do_round(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);

      // 3) Simultaneous requests twice: priority alternates.
      repeat (2) do_round(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h20, 1'b0, 1'b0);

      // 4) Adder never ready: abort with err.
      ready_mode = 2;
      @(negedge clk);
      e = '{id: 1'b0, res: 8'h00, co: 1'b0, ov: 1'b0, er: 1'b1};
      q.push_back(e);
      timed_op(8'h33, 8'h44, 1'b1, lat);
      check("timeout_latency", (lat - 2) >= TIMEOUT && (lat - 2) <= 17,
            $sformatf("ack %0d cycles after LO_WAIT entry, expected %0d..17", lat - 2, TIMEOUT));
      ready_mode = 0;

      // 5) Reset while waiting on the high pass: outputs drop at once, no ack.
      @(negedge clk);
      a0 = 8'h5A; b0 = 8'hA5; cin0 = 1'b0; sub0 = 1'b0;
      req0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      ready_mode = 2;
      @(posedge clk);
      #1;
      check("busy_in_hi_wait", busy == 1'b1, $sformatf("got %0b, expected 1", busy));
      rst_n = 1'b0;
      #1;
      check("reset_mid_op",
            {ack0, ack1, result, c_out, ovf, err, busy, bus.add_en, bus.add_a, bus.add_b, bus.add_cin} == '0,
            $sformatf("result=%02h busy=%0b add_en=%0b add_a=%0h, expected all 0",
                      result, busy, bus.add_en, bus.add_a));
      req0 = 1'b0;
      ptr  = 1'b0;
      ready_mode = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_round(1'b1, 1'b0, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

      // 6) Subtract select (effective only with the subtract option built in).
      do_round(1'b1, 1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

      // Random traffic with adder stalls.
      ready_mode = 1;
      for (int i = 0; i < 60; i++) begin
         int pat;
         pat = $urandom_range(1, 3);
         ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
         do_round(pat[0], pat[1], ra, rb, 1'($urandom), 1'($urandom),
                  rc, rd, 1'($urandom), 1'($urandom));
      end
      ready_mode = 0;

      repeat (5) @(negedge clk);
      check("scoreboard_empty", q.size() == 0, $sformatf("%0d responses outstanding, expected 0", q.size()));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
